pwm_complementary_core: RTL and testbench

- Single-clock PWM generator with complementary outputs.
- An internal prescaler divides clk by a runtime tick count and produces one-cycle step strobes.
- A free-running N-bit duty counter advances on each step and is compared with a duty value to produce pwm_out and its complement pwm_n_out.
- Used as a gate-drive source for an H-bridge/audio amplifier stage; the step strobe is also exported.

---
 rtl/pwm_complementary_core.sv | 81 ++++++++
 tb/tb_pwm_complementary_core.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_complementary_core.sv
// pwm_complementary_core
// PWM generator with complementary outputs for gate-drive use. A prescaler
// divides clk by a runtime tick count and emits a one-cycle step strobe; an
// N-bit duty counter advances on each step and is compared with a shadow
// duty register to produce pwm_out and its complement.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   ena        global enable; 0 freezes counters and drives all outputs low
//   ticks      clk cycles per step (0 stops the prescaler)
//   duty       high-time in steps per PWM period, taken at period boundaries
//   step       one-cycle prescaler strobe (registered)
//   pwm_out    PWM output (registered)
//   pwm_n_out  complementary PWM output (registered)
module pwm_complementary_core #(
    parameter int TICK_W = 14,
    parameter int N      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [TICK_W-1:0] ticks,
    input  logic [N-1:0]      duty,
    output logic              step,
    output logic              pwm_out,
    output logic              pwm_n_out
);

    localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
    localparam logic [N-1:0]      PCNT_MAX = {N{1'b1}};
    localparam logic [N-1:0]      PCNT_ONE = N'(1);

    logic [TICK_W-1:0] tick_cnt;
    logic [N-1:0]      pcount;
    logic [N-1:0]      duty_q;
    logic              pwm_hi;

    assign pwm_hi = (pcount < duty_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            step      <= 1'b0;
            pcount    <= '0;
            duty_q    <= duty;
            pwm_out   <= 1'b0;
            pwm_n_out <= 1'b0;
        end else if (!ena) begin
            step      <= 1'b0;
            pwm_out   <= 1'b0;
            pwm_n_out <= 1'b0;
        end else begin
            // A >= compare (not ==) lets a shrinking ticks value catch a
            // count that is already past the new terminal value.
            if (ticks == '0) begin
                tick_cnt <= '0;
                step     <= 1'b0;
            end else if (tick_cnt >= ticks - TICK_ONE) begin
                tick_cnt <= '0;
                step     <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt + TICK_ONE;
                step     <= 1'b0;
            end

            // The registered step advances the duty counter; a new duty is
            // only adopted as pcount wraps so a period is never truncated.
            if (step) begin
                pcount <= pcount + PCNT_ONE;
                if (pcount == PCNT_MAX) begin
                    duty_q <= duty;
                end
            end

            pwm_out   <= pwm_hi;
            pwm_n_out <= ~pwm_hi;
        end
    end

endmodule

// File: tb/tb_pwm_complementary_core.sv
module tb_pwm_complementary_core;

    localparam int TICK_W = 14;
    localparam int N      = 4;
    localparam int P      = 1 << N;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ena = 1'b0;
    logic [TICK_W-1:0] ticks = '0;
    logic [N-1:0]      duty = '0;
    logic              step;
    logic              pwm_out;
    logic              pwm_n_out;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_complementary_core #(.TICK_W(TICK_W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .ticks     (ticks),
        .duty      (duty),
        .step      (step),
        .pwm_out   (pwm_out),
        .pwm_n_out (pwm_n_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the period position is the total number of steps
    // taken modulo 2^N; a duty value is adopted whenever a step completes
    // a whole number of periods.
    int m_phase;
    int m_nsteps;
    int m_dq;
    bit m_step, m_pwm, m_pwmn;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int pos;
        if (rst) begin
            m_phase  = 0;
            m_step   = 1'b0;
            m_nsteps = 0;
            m_pwm    = 1'b0;
            m_pwmn   = 1'b0;
            m_dq     = int'(duty);
            m_valid  = 1'b1;
        end else if (!ena) begin
            m_step = 1'b0;
            m_pwm  = 1'b0;
            m_pwmn = 1'b0;
        end else begin
            pos    = m_nsteps % P;
            m_pwm  = (pos < m_dq);
            m_pwmn = !m_pwm;
            if (m_step) begin
                m_nsteps++;
                if (m_nsteps % P == 0) m_dq = int'(duty);
            end
            if (ticks == 0) begin
                m_phase = 0;
                m_step  = 1'b0;
            end else begin
                m_phase++;
                m_step = (m_phase >= int'(ticks));
                if (m_step) m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_step", int'(step), int'(m_step));
            check("model_pwm", int'(pwm_out), int'(m_pwm));
            check("model_pwm_n", int'(pwm_n_out), int'(m_pwmn));
            check("never_both_high", int'(pwm_out & pwm_n_out), 0);
        end
    end

    typedef struct {
        bit       v_rst;
        bit       v_ena;
        int       v_ticks;
        int       v_duty;
        bit       e_step;
        bit       e_pwm;
        bit       e_pwmn;
    } vec_t;

    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int t, input int d);
        rst = 1'b1; ena = 1'b0; ticks = TICK_W'(t); duty = N'(d);
        tick();
        rst = 1'b0; ena = 1'b1;
    endtask

    initial begin
        int hi1, lo1, hi2;

        tbl[0]  = '{1, 0, 3, 4, 0, 0, 0};
        tbl[1]  = '{0, 1, 3, 4, 0, 1, 0};
        tbl[2]  = '{0, 1, 3, 4, 0, 1, 0};
        tbl[3]  = '{0, 1, 3, 4, 1, 1, 0};
        tbl[4]  = '{0, 1, 3, 4, 0, 1, 0};
        tbl[5]  = '{0, 0, 3, 4, 0, 0, 0};
        tbl[6]  = '{0, 1, 3, 4, 0, 1, 0};
        tbl[7]  = '{0, 1, 3, 4, 1, 1, 0};
        tbl[8]  = '{1, 1, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 0, 1, 0, 1};
        tbl[10] = '{0, 1, 1, 0, 1, 0, 1};

        for (int i = 0; i < 11; i++) begin
            rst   = tbl[i].v_rst;
            ena   = tbl[i].v_ena;
            ticks = TICK_W'(tbl[i].v_ticks);
            duty  = N'(tbl[i].v_duty);
            tick();
            check($sformatf("vec%0d_step", i), int'(step), int'(tbl[i].e_step));
            check($sformatf("vec%0d_pwm", i), int'(pwm_out), int'(tbl[i].e_pwm));
            check($sformatf("vec%0d_pwm_n", i), int'(pwm_n_out), int'(tbl[i].e_pwmn));
        end

        // ticks=3: edges 3..50 span one full period at duty 4; the duty
        // change to 12 mid-period only shows in the following period.
        do_reset(3, 4);
        hi1 = 0; lo1 = 0; hi2 = 0;
        for (int e = 2; e <= 98; e++) begin
            tick();
            if (e == 10) duty = N'(12);
            if (e >= 3 && e <= 50) begin
                hi1 += int'(pwm_out);
                lo1 += int'(pwm_n_out);
            end
            if (e >= 51 && e <= 98) hi2 += int'(pwm_out);
        end
        check("period1_pwm_high", hi1, 12);
        check("period1_pwm_n_high", lo1, 36);
        check("period2_pwm_high_after_change", hi2, 36);

        // ticks=1 duty sweep: each 16-edge window is exactly one period.
        for (int d = 0; d < P; d++) begin
            do_reset(1, d);
            hi1 = 0; hi2 = 0;
            for (int e = 2; e <= 34; e++) begin
                tick();
                if (e >= 3 && e <= 18) hi1 += int'(pwm_out);
                if (e >= 19) hi2 += int'(pwm_out);
            end
            check($sformatf("sweep_d%0d_p1", d), hi1, d);
            check($sformatf("sweep_d%0d_p2", d), hi2, d);
        end

        // ticks=0: prescaler stopped, pcount stays 0, so duty 8 keeps pwm high.
        do_reset(0, 8);
        hi1 = 0; lo1 = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            hi1 += int'(step);
            lo1 += int'(pwm_out);
        end
        check("ticks0_no_step", hi1, 0);
        check("ticks0_pwm_const", lo1, 40);

        // Random traffic checked cycle by cycle against the model.
        do_reset(2, 5);
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) ticks = TICK_W'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) duty = N'($urandom_range(0, P - 1));
            tick();
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
